// File: rtl/pad_enable_seq.sv
// I/O ring power-up sequencer: receivers on, staggered output enables, then core release.
// Optional PAD_SEQ_STATUS_EN adds off_count (saturating TX_OFF entries) and state_o.
//
// state   | meaning
// IDLE    | ring off, waiting for the first clock after reset release
// RX_ON   | receivers enabled, settling; config accepted
// STAGGER | enabling masked-in outputs one at a time, then final wait
// RUN     | ring fully up, core out of reset
// TX_OFF  | outputs tri-stated, core held in reset; config accepted
module pad_enable_seq #(
  parameter int NUM_IN         = 3,
  parameter int NUM_OUT        = 2,
  parameter int SETTLE_CYCLES  = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int CNT_W          = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               force_off,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [NUM_OUT-1:0] cfg_mask,
  output logic [NUM_IN-1:0]  r_en,
  output logic [NUM_OUT-1:0] out_en,
  output logic               core_rst_n,
  output logic               busy
`ifdef PAD_SEQ_STATUS_EN
  ,
  output logic [7:0]         off_count,
  output logic [2:0]         state_o
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RX_ON   = 3'd1,
    STAGGER = 3'd2,
    RUN     = 3'd3,
    TX_OFF  = 3'd4
  } state_t;

  localparam int                IDX_W        = $clog2(NUM_OUT + 1);
  localparam logic [IDX_W-1:0]  IDX_NONE     = IDX_W'(NUM_OUT);
  localparam logic [CNT_W-1:0]  SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);

  state_t               state_q, state_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n;
  logic [IDX_W-1:0]     idx_q, idx_n;
  logic [NUM_OUT-1:0]   mask_q, mask_n;
  logic [NUM_OUT-1:0]   out_en_q, out_en_n;
  logic                 rx_on_q, rx_on_n;
  logic                 core_rel_q, core_rel_n;
  logic                 cfg_xfer;
  logic [IDX_W-1:0]     first_entry, first_step;
  logic [NUM_OUT-1:0]   entry_out;
  logic [IDX_W-1:0]     entry_idx;
  logic [CNT_W-1:0]     entry_cnt;

  // Lowest masked-in index at or above start; IDX_NONE when there is none.
  function automatic logic [IDX_W-1:0] first_set(input logic [NUM_OUT-1:0] m,
                                                 input logic [IDX_W-1:0]   start);
    logic [IDX_W-1:0] r;
    r = IDX_NONE;
    for (int i = NUM_OUT - 1; i >= 0; i--) begin
      if ((IDX_W'(i) >= start) && m[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  function automatic logic [NUM_OUT-1:0] onehot(input logic [IDX_W-1:0] f);
    logic [NUM_OUT-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (IDX_W'(i) == f) r[i] = 1'b1;
    end
    return r;
  endfunction

  assign cfg_ready  = (state_q == RX_ON) || (state_q == TX_OFF);
  assign busy       = (state_q != RUN);
  assign r_en       = {NUM_IN{rx_on_q}};
  assign out_en     = out_en_q;
  assign core_rst_n = core_rel_q;

  always_comb begin
    cfg_xfer    = cfg_valid && cfg_ready;
    mask_n      = cfg_xfer ? cfg_mask : mask_q;
    first_entry = first_set(mask_n, '0);
    first_step  = first_set(mask_q, idx_q);

    // Stagger entry uses the mask as updated on this same edge.
    entry_out = '0;
    entry_idx = IDX_NONE;
    entry_cnt = '0;
    if (first_entry != IDX_NONE) begin
      entry_out = onehot(first_entry);
      entry_idx = first_entry + IDX_W'(1);
      entry_cnt = STAGGER_LOAD;
    end

    state_n  = state_q;
    cnt_n    = cnt_q;
    idx_n    = idx_q;
    out_en_n = out_en_q;
    rx_on_n  = rx_on_q;

    case (state_q)
      IDLE: begin
        state_n = RX_ON;
        rx_on_n = 1'b1;
        cnt_n   = SETTLE_LOAD;
      end
      RX_ON: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CNT_W'(1);
        end else if (force_off) begin
          state_n = TX_OFF;
        end else begin
          state_n  = STAGGER;
          out_en_n = entry_out;
          idx_n    = entry_idx;
          cnt_n    = entry_cnt;
        end
      end
      STAGGER: begin
        if (force_off) begin
          state_n  = TX_OFF;
          out_en_n = '0;
        end else if (cnt_q != '0) begin
          cnt_n = cnt_q - CNT_W'(1);
        end else if (first_step != IDX_NONE) begin
          out_en_n = out_en_q | onehot(first_step);
          idx_n    = first_step + IDX_W'(1);
          cnt_n    = STAGGER_LOAD;
        end else begin
          state_n = RUN;
        end
      end
      RUN: begin
        if (force_off) begin
          state_n  = TX_OFF;
          out_en_n = '0;
        end
      end
      TX_OFF: begin
        if (!force_off) begin
          state_n  = STAGGER;
          out_en_n = entry_out;
          idx_n    = entry_idx;
          cnt_n    = entry_cnt;
        end
      end
      default: begin
        state_n  = IDLE;
        out_en_n = '0;
      end
    endcase

    core_rel_n = (state_n == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      mask_q     <= '1;
      out_en_q   <= '0;
      rx_on_q    <= 1'b0;
      core_rel_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      idx_q      <= idx_n;
      mask_q     <= mask_n;
      out_en_q   <= out_en_n;
      rx_on_q    <= rx_on_n;
      core_rel_q <= core_rel_n;
    end
  end

`ifdef PAD_SEQ_STATUS_EN
  logic [7:0] off_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      off_count_q <= '0;
    end else if ((state_n == TX_OFF) && (state_q != TX_OFF) && (off_count_q != 8'hFF)) begin
      off_count_q <= off_count_q + 8'd1;
    end
  end

  assign off_count = off_count_q;
  assign state_o   = state_q;
`endif

endmodule
